// File: rtl/sram_bus_arbiter_if.sv
// Signal bundle between the fetch/load-store ports, the arbiter and the bus bridge.
// The arbiter uses the slave modport; the surrounding environment uses master.
interface sram_bus_arbiter_if #(
    parameter int unsigned ADDR_W = 64,
    parameter int unsigned DATA_W = 64
);
    logic                  if_req_valid;
    logic                  if_req_op;
    logic [ADDR_W-1:0]     if_addr;
    logic                  if_addr_ok;
    logic                  if_data_ok;
    logic [DATA_W-1:0]     if_rdata;

    logic                  mem_req_valid;
    logic                  mem_req_op;
    logic [ADDR_W-1:0]     mem_addr;
    logic [DATA_W-1:0]     mem_wdata;
    logic [DATA_W/8-1:0]   mem_wmask;
    logic                  mem_addr_ok;
    logic                  mem_data_ok;
    logic [DATA_W-1:0]     mem_rdata;

    logic                  bus_req_valid;
    logic                  bus_req_op;
    logic [ADDR_W-1:0]     bus_addr;
    logic [DATA_W-1:0]     bus_wdata;
    logic [DATA_W/8-1:0]   bus_wmask;
    logic                  bus_addr_ok;
    logic                  bus_data_ok;
    logic [DATA_W-1:0]     bus_rdata;

    modport slave (
        input  if_req_valid, if_req_op, if_addr,
        output if_addr_ok, if_data_ok, if_rdata,
        input  mem_req_valid, mem_req_op, mem_addr, mem_wdata, mem_wmask,
        output mem_addr_ok, mem_data_ok, mem_rdata,
        output bus_req_valid, bus_req_op, bus_addr, bus_wdata, bus_wmask,
        input  bus_addr_ok, bus_data_ok, bus_rdata
    );

    modport master (
        output if_req_valid, if_req_op, if_addr,
        input  if_addr_ok, if_data_ok, if_rdata,
        output mem_req_valid, mem_req_op, mem_addr, mem_wdata, mem_wmask,
        input  mem_addr_ok, mem_data_ok, mem_rdata,
        input  bus_req_valid, bus_req_op, bus_addr, bus_wdata, bus_wmask,
        output bus_addr_ok, bus_data_ok, bus_rdata
    );
endinterface

// File: rtl/sram_bus_arbiter.sv
// Shares one split-transaction SRAM-like bus between the fetch and load/store ports.
// Define ARB_ROUND_ROBIN_EN for round-robin under contention; default is mem-over-fetch.
module sram_bus_arbiter #(
    parameter int unsigned ADDR_W      = 64,
    parameter int unsigned DATA_W      = 64,
    parameter int unsigned OUTSTANDING = 2
) (
    input logic               clk,
    input logic               rst,
    sram_bus_arbiter_if.slave arb
);
    localparam int unsigned     PtrW   = $clog2(OUTSTANDING);
    localparam int unsigned     CntW   = PtrW + 1;
    localparam logic [CntW-1:0] MaxCnt = CntW'(OUTSTANDING);

    typedef enum logic [1:0] {StFree, StLockIf, StLockMem} lock_state_e;

    lock_state_e state_q, state_d;

    logic [OUTSTANDING-1:0] owner_q;  // 1 = mem, 0 = fetch
    logic [PtrW-1:0]        wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0]        count_q, count_d;

    logic grant_if, grant_mem, sel_if, sel_mem;
    logic space, req, push, pop, head;

    logic [ADDR_W-1:0]   addr_mux;
    logic [DATA_W-1:0]   wdata_mux;
    logic [DATA_W/8-1:0] wmask_mux;

`ifdef ARB_ROUND_ROBIN_EN
    logic rr_last_q;  // 1 = mem won last accepted request
`endif

    // Lock state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StFree;
        end else begin
            state_q <= state_d;
        end
    end

    // A request left pending by the bus pins the grant until it is accepted or withdrawn
    always_comb begin
        state_d = StFree;
        if (req && !arb.bus_addr_ok) begin
            state_d = grant_mem ? StLockMem : StLockIf;
        end
    end

    always_comb begin
        grant_if  = 1'b0;
        grant_mem = 1'b0;
        unique case (state_q)
            StLockIf:  grant_if  = 1'b1;
            StLockMem: grant_mem = 1'b1;
            default: begin
`ifdef ARB_ROUND_ROBIN_EN
                if (arb.mem_req_valid && arb.if_req_valid) begin
                    grant_mem = ~rr_last_q;
                    grant_if  = rr_last_q;
                end else begin
                    grant_mem = arb.mem_req_valid;
                    grant_if  = arb.if_req_valid;
                end
`else
                // mem is the older instruction, so it must win to avoid deadlock
                grant_mem = arb.mem_req_valid;
                grant_if  = arb.if_req_valid & ~arb.mem_req_valid;
`endif
            end
        endcase
    end

    assign pop     = ~rst & arb.bus_data_ok & (count_q != '0);
    assign space   = (count_q < MaxCnt) | pop;
    assign sel_if  = ~rst & grant_if;
    assign sel_mem = ~rst & grant_mem;
    assign req     = space & ((sel_mem & arb.mem_req_valid) | (sel_if & arb.if_req_valid));
    assign push    = req & arb.bus_addr_ok;
    assign head    = owner_q[rd_ptr_q];

    always_comb begin
        addr_mux  = '0;
        wdata_mux = '0;
        wmask_mux = '0;
        if (sel_mem) begin
            addr_mux  = arb.mem_addr;
            wdata_mux = arb.mem_wdata;
            wmask_mux = arb.mem_wmask;
        end else if (sel_if) begin
            addr_mux  = arb.if_addr;
        end
    end

    assign arb.bus_req_valid = req;
    assign arb.bus_req_op    = sel_mem ? arb.mem_req_op : (sel_if & arb.if_req_op);
    assign arb.bus_addr      = addr_mux;
    assign arb.bus_wdata     = wdata_mux;
    assign arb.bus_wmask     = wmask_mux;

    assign arb.if_addr_ok  = push & sel_if;
    assign arb.mem_addr_ok = push & sel_mem;
    assign arb.if_data_ok  = pop & ~head;
    assign arb.mem_data_ok = pop & head;
    assign arb.if_rdata    = rst ? '0 : arb.bus_rdata;
    assign arb.mem_rdata   = rst ? '0 : arb.bus_rdata;

    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CntW'(1);
            2'b01:   count_d = count_q - CntW'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointers wrap naturally since OUTSTANDING is a power of two
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) owner_q[wr_ptr_q] <= sel_mem;
    end

`ifdef ARB_ROUND_ROBIN_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_last_q <= 1'b1;
        end else if (push) begin
            rr_last_q <= sel_mem;
        end
    end
`endif
endmodule

// File: tb/tb_sram_bus_arbiter.sv
// Randomised scoreboard bench for sram_bus_arbiter: a transaction-level model predicts
// grants and accepts; a monitor matches every data_ok against the expected-response queue.
module tb_sram_bus_arbiter;
    localparam int unsigned AW  = 64;
    localparam int unsigned DW  = 64;
    localparam int unsigned OUT = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    sram_bus_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus_if ();

    sram_bus_arbiter #(
        .ADDR_W(AW),
        .DATA_W(DW),
        .OUTSTANDING(OUT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .arb(bus_if)
    );

    typedef struct {
        bit            owner;  // 1 = mem
        logic [DW-1:0] rdata;
    } resp_t;

    resp_t         exp_q[$];
    logic [DW-1:0] bus_pend[$];
    int            checks = 0;
    int            errors = 0;

    int              lock_port = -1;
    bit              rr_last   = 1'b1;
    bit              if_act    = 1'b0;
    bit              mem_act   = 1'b0;
    bit              mem_op    = 1'b0;
    logic [AW-1:0]   if_a      = '0;
    logic [AW-1:0]   mem_a     = '0;
    logic [DW-1:0]   mem_wd    = '0;
    logic [DW/8-1:0] mem_wm    = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic drive(input bit a_ok, input bit d_ok);
        bus_if.if_req_valid  = if_act;
        bus_if.if_req_op     = 1'b0;
        bus_if.if_addr       = if_a;
        bus_if.mem_req_valid = mem_act;
        bus_if.mem_req_op    = mem_op;
        bus_if.mem_addr      = mem_a;
        bus_if.mem_wdata     = mem_wd;
        bus_if.mem_wmask     = mem_wm;
        bus_if.bus_addr_ok   = a_ok;
        bus_if.bus_data_ok   = d_ok;
        bus_if.bus_rdata     = (bus_pend.size() != 0) ? bus_pend[0] : {$urandom, $urandom};
    endtask

    // One bus cycle: drive, predict from the model, compare, then advance the model.
    task automatic cycle(input bit a_ok, input bit d_ok);
        bit            pop, space, req;
        int            w;
        logic [DW-1:0] rd;
        drive(a_ok, d_ok);
        #1;
        pop   = d_ok && (bus_pend.size() != 0);
        space = (bus_pend.size() < OUT) || pop;
        if (lock_port >= 0) w = lock_port;
        else if (if_act && mem_act) begin
`ifdef ARB_ROUND_ROBIN_EN
            w = rr_last ? 0 : 1;
`else
            w = 1;
`endif
        end else if (mem_act) w = 1;
        else if (if_act) w = 0;
        else w = -1;
        req = space && ((w == 1 && mem_act) || (w == 0 && if_act));

        check("bus_req_valid", 64'(bus_if.bus_req_valid), 64'(req));
        if (req) begin
            check("bus_addr", bus_if.bus_addr, (w == 1) ? mem_a : if_a);
            check("bus_req_op", 64'(bus_if.bus_req_op), (w == 1) ? 64'(mem_op) : 64'd0);
            check("bus_wdata", bus_if.bus_wdata, (w == 1) ? mem_wd : 64'd0);
            check("bus_wmask", 64'(bus_if.bus_wmask), (w == 1) ? 64'(mem_wm) : 64'd0);
        end
        check("if_addr_ok", 64'(bus_if.if_addr_ok), 64'(req && a_ok && w == 0));
        check("mem_addr_ok", 64'(bus_if.mem_addr_ok), 64'(req && a_ok && w == 1));

        if (pop) void'(bus_pend.pop_front());
        if (req && a_ok) begin
            rd = {$urandom, $urandom};
            bus_pend.push_back(rd);
            exp_q.push_back('{owner: (w == 1), rdata: rd});
            if (w == 1) mem_act = 1'b0;
            else if_act = 1'b0;
            rr_last   = (w == 1);
            lock_port = -1;
        end else begin
            lock_port = req ? w : -1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic gen();
        if (if_act && $urandom_range(19) == 0) if_act = 1'b0;
        else if (!if_act && $urandom_range(1) == 0) begin
            if_act = 1'b1;
            if_a   = {$urandom, $urandom};
        end
        if (mem_act && $urandom_range(19) == 0) mem_act = 1'b0;
        else if (!mem_act && $urandom_range(1) == 0) begin
            mem_act = 1'b1;
            mem_a   = {$urandom, $urandom};
            mem_op  = 1'($urandom_range(1));
            mem_wd  = {$urandom, $urandom};
            mem_wm  = 8'($urandom);
        end
    endtask

    task automatic do_reset(input int n);
        logic [10:0] outs;
        check("backlog_before_reset", 64'(exp_q.size()), 64'(bus_pend.size()));
        rst = 1'b1;
        repeat (n) begin
            drive(1'b1, 1'b1);
            #1;
            outs = {bus_if.bus_req_valid, bus_if.bus_req_op, bus_if.if_addr_ok,
                    bus_if.mem_addr_ok, bus_if.if_data_ok, bus_if.mem_data_ok,
                    |bus_if.bus_addr, |bus_if.bus_wdata, |bus_if.bus_wmask,
                    |bus_if.if_rdata, |bus_if.mem_rdata};
            check("reset_outputs", 64'(outs), 64'd0);
            @(posedge clk);
            #1;
        end
        rst = 1'b0;
        exp_q.delete();
        bus_pend.delete();
        lock_port = -1;
        rr_last   = 1'b1;
    endtask

    // Response monitor: every data_ok must match the oldest expected response
    always @(negedge clk) begin
        resp_t e;
        if (!rst && (bus_if.if_data_ok || bus_if.mem_data_ok)) begin
            if (exp_q.size() == 0) begin
                check("data_ok_unexpected", 64'({bus_if.mem_data_ok, bus_if.if_data_ok}), 64'd0);
            end else begin
                e = exp_q.pop_front();
                check("data_ok_owner", 64'({bus_if.mem_data_ok, bus_if.if_data_ok}),
                      e.owner ? 64'd2 : 64'd1);
                check("rdata", e.owner ? bus_if.mem_rdata : bus_if.if_rdata, e.rdata);
            end
        end
    end

    initial begin
        drive(1'b0, 1'b0);
        @(posedge clk);
        #1;
        do_reset(2);

        // Spurious response with nothing outstanding
        cycle(1'b1, 1'b1);

        // Single fetch, response two cycles later
        if_act = 1'b1;
        if_a   = 64'h8000_0000;
        cycle(1'b1, 1'b0);
        cycle(1'b0, 1'b0);
        cycle(1'b0, 1'b1);

        // Contention, then a second contention cycle
        if_act  = 1'b1;
        if_a    = 64'h8000_0004;
        mem_act = 1'b1;
        mem_a   = 64'h8000_1000;
        mem_op  = 1'b1;
        mem_wd  = 64'h1122_3344_5566_7788;
        mem_wm  = 8'hFF;
        cycle(1'b1, 1'b0);
        mem_act = 1'b1;
        mem_a   = 64'h8000_1008;
        cycle(1'b1, 1'b1);
        cycle(1'b1, 1'b1);
        cycle(1'b0, 1'b1);
        cycle(1'b0, 1'b1);

        // Lock hold: fetch stalls three cycles while mem rises
        if_act = 1'b1;
        if_a   = 64'h8000_0100;
        cycle(1'b0, 1'b1);
        mem_act = 1'b1;
        mem_a   = 64'h8000_2000;
        mem_op  = 1'b0;
        cycle(1'b0, 1'b1);
        cycle(1'b0, 1'b1);
        cycle(1'b1, 1'b1);
        cycle(1'b1, 1'b1);
        cycle(1'b0, 1'b1);
        cycle(1'b0, 1'b1);

        // Full, then pop and push in the same cycle; three-deep ordering
        if_act = 1'b1;
        if_a   = 64'h8000_0200;
        cycle(1'b1, 1'b0);
        mem_act = 1'b1;
        mem_a   = 64'h8000_3000;
        cycle(1'b1, 1'b0);
        if_act = 1'b1;
        if_a   = 64'h8000_0204;
        cycle(1'b1, 1'b0);
        cycle(1'b1, 1'b1);
        cycle(1'b0, 1'b1);
        cycle(1'b0, 1'b1);

        // Reset with one outstanding, then a response must be ignored
        if_act = 1'b1;
        if_a   = 64'h8000_0300;
        cycle(1'b1, 1'b0);
        do_reset(1);
        cycle(1'b0, 1'b1);

        for (int i = 0; i < 4000; i++) begin
            gen();
            cycle(1'($urandom_range(3) != 0),
                  (bus_pend.size() != 0) ? 1'($urandom_range(2) == 0)
                                         : 1'($urandom_range(9) == 0));
            if (i % 1000 == 999) do_reset(1 + int'($urandom_range(1)));
        end

        if_act  = 1'b0;
        mem_act = 1'b0;
        for (int i = 0; i < 20 && bus_pend.size() != 0; i++) cycle(1'b1, 1'b1);
        check("drain_done", 64'(bus_pend.size()), 64'd0);
        @(negedge clk);
        #1;
        check("backlog_final", 64'(exp_q.size()), 64'(bus_pend.size()));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
